axis_phat_div_feed: RTL and testbench

Upstream feeder for the PHAT-weighting divider pair in the DOA chain. Accepts one complex cross-spectrum bin per beat (signed 32-bit re/im) and computes an approximate magnitude |X|. It then broadcasts {divisor, dividend} beats to two divider channels (re/|X| and im/|X|). The two divider result streams are recombined downstream into 4096-bin frames for the IFFT.

---
 rtl/axis_phat_div_feed_if.sv | 10 +
 rtl/axis_phat_div_feed.sv | 162 ++++++++++++++++
 tb/tb_axis_phat_div_feed.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_phat_div_feed_if.sv
// AXI4-Stream link used by the PHAT divider feeder: one 64-bit beat per
// handshake. The master drives data/valid; the slave drives ready.
interface axis_phat_div_feed_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_phat_div_feed.sv
// PHAT-weighting divider feeder. Takes one complex cross-spectrum bin per
// beat, estimates |X| with alpha-max-beta-min (beta = 3/8) and broadcasts
// {|X|, re} and {|X|, im} to the two divider channels. A two-stage pipeline
// (S1: operands + absolute values, S2: output register) lets the two
// channels complete independently while each bin is emitted exactly once
// per channel.
module axis_phat_div_feed (
  input  logic                        axis_aclk,
  input  logic                        axis_aresetn,
  axis_phat_div_feed_if.slave         s_axis,
  axis_phat_div_feed_if.master        m00_axis,
  axis_phat_div_feed_if.master        m01_axis
);

  localparam logic [31:0] MAG_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // ---------------------------------------------------------------------
  // Input component split and absolute value (lane 0 = re, lane 1 = im).
  // The most negative value has no positive twin, so it saturates.
  // ---------------------------------------------------------------------
  logic [31:0] in_comp [2];
  logic [31:0] in_abs  [2];

  assign in_comp[0] = s_axis.tdata[31:0];
  assign in_comp[1] = s_axis.tdata[63:32];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      assign in_abs[gi] = (in_comp[gi] == INT_MIN) ? MAG_MAX :
                          (in_comp[gi][31] ? (~in_comp[gi] + 32'd1) : in_comp[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------
  logic        s1_full_reg, s1_full_next;
  logic [31:0] s1_re_reg, s1_im_reg;
  logic [31:0] s1_ar_reg, s1_ai_reg;

  logic        s2_full_reg, s2_full_next;
  logic        d0_reg, d0_next;
  logic        d1_reg, d1_next;
  logic [31:0] s2_div_reg, s2_re_reg, s2_im_reg;

  // Handshake and transfer strobes
  logic s_hs;
  logic m0_hs;
  logic m1_hs;
  logic s2_drain;
  logic s2_load;

  // Magnitude estimate from S1
  logic [31:0] mx;
  logic [31:0] mn;
  logic [32:0] mag33;
  logic [31:0] div_val;

  // ---------------------------------------------------------------------
  // Output handshakes. A channel stops presenting once it has taken the
  // current S2 beat; S2 drains only when both channels have taken it.
  // ---------------------------------------------------------------------
  assign m00_axis.tvalid = s2_full_reg & ~d0_reg;
  assign m01_axis.tvalid = s2_full_reg & ~d1_reg;
  assign m00_axis.tdata  = {s2_div_reg, s2_re_reg};
  assign m01_axis.tdata  = {s2_div_reg, s2_im_reg};

  assign m0_hs    = m00_axis.tvalid & m00_axis.tready;
  assign m1_hs    = m01_axis.tvalid & m01_axis.tready;
  assign s2_drain = s2_full_reg & (d0_reg | m0_hs) & (d1_reg | m1_hs);
  assign s2_load  = s1_full_reg & (~s2_full_reg | s2_drain);

  assign s_axis.tready = ~s1_full_reg | s2_load;
  assign s_hs          = s_axis.tvalid & s_axis.tready;

  // Alpha-max-beta-min magnitude, clamped into a positive non-zero divisor
  always_comb begin
    mx      = s1_ar_reg;
    mn      = s1_ai_reg;
    if (s1_ai_reg > s1_ar_reg) begin
      mx = s1_ai_reg;
      mn = s1_ar_reg;
    end
    mag33   = {1'b0, mx} + {3'b000, mn[31:2]} + {4'b0000, mn[31:3]};
    div_val = mag33[31:0];
    if (mag33 > {1'b0, MAG_MAX}) begin
      div_val = MAG_MAX;
    end else if (mag33 == 33'd0) begin
      div_val = 32'd1;
    end
  end

  // Next-state for occupancy and per-channel done flags
  always_comb begin
    s1_full_next = s1_full_reg;
    if (s_hs) begin
      s1_full_next = 1'b1;
    end else if (s2_load) begin
      s1_full_next = 1'b0;
    end

    s2_full_next = s2_full_reg;
    if (s2_load) begin
      s2_full_next = 1'b1;
    end else if (s2_drain) begin
      s2_full_next = 1'b0;
    end

    d0_next = d0_reg;
    d1_next = d1_reg;
    if (s2_load || s2_drain) begin
      d0_next = 1'b0;
      d1_next = 1'b0;
    end else begin
      if (m0_hs) d0_next = 1'b1;
      if (m1_hs) d1_next = 1'b1;
    end
  end

  // S1 register: captures the bin and its absolute values on input handshake
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      s1_full_reg <= 1'b0;
      s1_re_reg   <= 32'd0;
      s1_im_reg   <= 32'd0;
      s1_ar_reg   <= 32'd0;
      s1_ai_reg   <= 32'd0;
    end else begin
      s1_full_reg <= s1_full_next;
      if (s_hs) begin
        s1_re_reg <= in_comp[0];
        s1_im_reg <= in_comp[1];
        s1_ar_reg <= in_abs[0];
        s1_ai_reg <= in_abs[1];
      end
    end
  end

  // S2 register: output beat held until both channels have consumed it
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      s2_full_reg <= 1'b0;
      d0_reg      <= 1'b0;
      d1_reg      <= 1'b0;
      s2_div_reg  <= 32'd0;
      s2_re_reg   <= 32'd0;
      s2_im_reg   <= 32'd0;
    end else begin
      s2_full_reg <= s2_full_next;
      d0_reg      <= d0_next;
      d1_reg      <= d1_next;
      if (s2_load) begin
        s2_div_reg <= div_val;
        s2_re_reg  <= s1_re_reg;
        s2_im_reg  <= s1_im_reg;
      end
    end
  end

endmodule

// File: tb/tb_axis_phat_div_feed.sv
// Self-checking bench for axis_phat_div_feed: directed vector table,
// randomized streaming against a queue-based reference model, and
// hand-written split-completion and reset sequences.
module tb_axis_phat_div_feed;

  logic axis_aclk    = 1'b0;
  logic axis_aresetn = 1'b0;

  axis_phat_div_feed_if s_axis ();
  axis_phat_div_feed_if m00_axis ();
  axis_phat_div_feed_if m01_axis ();

  axis_phat_div_feed dut (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .s_axis       (s_axis),
    .m00_axis     (m00_axis),
    .m01_axis     (m01_axis)
  );

  always #5 axis_aclk = ~axis_aclk;

  int checks = 0;
  int errors = 0;

  logic [31:0] edge_vals [4];

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [31:0] div;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference divisor from the magnitude rules, using plain integer arithmetic
  function automatic logic [31:0] ref_div(input logic [31:0] re, input logic [31:0] im);
    longint a, b, mx, mn, mag;
    a = longint'($signed(re));
    b = longint'($signed(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (b > 64'sd2147483647) b = 64'sd2147483647;
    mx  = (a > b) ? a : b;
    mn  = (a > b) ? b : a;
    mag = mx + mn / 4 + mn / 8;
    if (mag > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (mag == 0) return 32'd1;
    return mag[31:0];
  endfunction

  // Single bin with both readies high: checks 2-cycle latency and data
  task automatic run_vector(input vec_t v, input int idx);
    @(posedge axis_aclk); #1;
    s_axis.tdata     = {v.im, v.re};
    s_axis.tvalid    = 1'b1;
    m00_axis.tready  = 1'b1;
    m01_axis.tready  = 1'b1;
    @(negedge axis_aclk);
    check($sformatf("vec%0d s_tready", idx), s_axis.tready, 1);
    @(posedge axis_aclk); #1;
    s_axis.tvalid = 1'b0;
    @(negedge axis_aclk);
    check($sformatf("vec%0d valids N+1", idx), {m00_axis.tvalid, m01_axis.tvalid}, 2'b00);
    @(negedge axis_aclk);
    check($sformatf("vec%0d valids N+2", idx), {m00_axis.tvalid, m01_axis.tvalid}, 2'b11);
    check($sformatf("vec%0d m00 data", idx), m00_axis.tdata, {v.div, v.re});
    check($sformatf("vec%0d m01 data", idx), m01_axis.tdata, {v.div, v.im});
    @(negedge axis_aclk);
    check($sformatf("vec%0d valids after", idx), {m00_axis.tvalid, m01_axis.tvalid}, 2'b00);
  endtask

  // Random stream with per-cycle ready probabilities (percent)
  task automatic run_stream(input string tag, input int n, input int ps,
                            input int p0, input int p1, input bit thru);
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] prev_d0, prev_d1, exp_beat;
    logic [31:0] re, im, dv;
    int sent = 0, got0 = 0, got1 = 0, cyc = 0;
    int first_in = -1, first_out = -1, last_out = -1;
    int occ;
    bit hs_s = 1'b0, hs0, hs1, drain, stall0 = 1'b0, stall1 = 1'b0;
    prev_d0 = '0;
    prev_d1 = '0;
    while ((got0 < n || got1 < n) && cyc < n * 20 + 200) begin
      @(posedge axis_aclk); #1;
      if (!s_axis.tvalid || hs_s) begin
        if (sent < n && int'($urandom_range(99)) < ps) begin
          re = $urandom;
          im = $urandom;
          if ($urandom_range(7) == 0) re = edge_vals[$urandom_range(3)];
          if ($urandom_range(7) == 0) im = edge_vals[$urandom_range(3)];
          s_axis.tdata  = {im, re};
          s_axis.tvalid = 1'b1;
          sent++;
        end else begin
          s_axis.tvalid = 1'b0;
        end
      end
      m00_axis.tready = (int'($urandom_range(99)) < p0);
      m01_axis.tready = (int'($urandom_range(99)) < p1);
      @(negedge axis_aclk);
      hs_s = s_axis.tvalid && s_axis.tready;
      hs0  = m00_axis.tvalid && m00_axis.tready;
      hs1  = m01_axis.tvalid && m01_axis.tready;
      if (stall0) begin
        check({tag, " m00 held valid"}, m00_axis.tvalid, 1);
        check({tag, " m00 held data"}, m00_axis.tdata, prev_d0);
      end
      if (stall1) begin
        check({tag, " m01 held valid"}, m01_axis.tvalid, 1);
        check({tag, " m01 held data"}, m01_axis.tdata, prev_d1);
      end
      // Bins in flight = accepted but not yet taken by both channels
      occ   = (q0.size() > q1.size()) ? q0.size() : q1.size();
      drain = (q0.size() < occ || hs0) && (q1.size() < occ || hs1);
      check({tag, " s_tready"}, s_axis.tready, !(occ == 2 && !drain));
      if (hs0) begin
        check({tag, " m00 beat expected"}, q0.size() > 0, 1);
        if (q0.size() > 0) begin
          exp_beat = q0.pop_front();
          check({tag, " m00 data"}, m00_axis.tdata, exp_beat);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got0++;
      end
      if (hs1) begin
        check({tag, " m01 beat expected"}, q1.size() > 0, 1);
        if (q1.size() > 0) begin
          exp_beat = q1.pop_front();
          check({tag, " m01 data"}, m01_axis.tdata, exp_beat);
        end
        got1++;
      end
      if (hs_s) begin
        dv = ref_div(s_axis.tdata[31:0], s_axis.tdata[63:32]);
        q0.push_back({dv, s_axis.tdata[31:0]});
        q1.push_back({dv, s_axis.tdata[63:32]});
        if (first_in < 0) first_in = cyc;
      end
      stall0  = m00_axis.tvalid && !m00_axis.tready;
      stall1  = m01_axis.tvalid && !m01_axis.tready;
      prev_d0 = m00_axis.tdata;
      prev_d1 = m01_axis.tdata;
      cyc++;
    end
    @(posedge axis_aclk); #1;
    s_axis.tvalid = 1'b0;
    check({tag, " m00 count"}, got0, n);
    check({tag, " m01 count"}, got1, n);
    check({tag, " leftover"}, q0.size() + q1.size(), 0);
    if (thru) begin
      check({tag, " first latency"}, first_out - first_in, 2);
      check({tag, " output span"}, last_out - first_out, n - 1);
    end
  endtask

  initial begin
    s_axis.tdata    = '0;
    s_axis.tvalid   = 1'b0;
    m00_axis.tready = 1'b0;
    m01_axis.tready = 1'b0;

    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'h8000_0000;
    edge_vals[2] = 32'h7FFF_FFFF;
    edge_vals[3] = 32'hFFFF_FFFF;

    vecs[0] = '{re: 32'd3,          im: 32'hFFFF_FFFC, div: 32'd4};
    vecs[1] = '{re: 32'd0,          im: 32'd0,         div: 32'd1};
    vecs[2] = '{re: 32'h8000_0000,  im: 32'h8000_0000, div: 32'h7FFF_FFFF};
    vecs[3] = '{re: 32'd1,          im: 32'd0,         div: 32'd1};
    vecs[4] = '{re: 32'd8,          im: 32'd8,         div: 32'd11};
    vecs[5] = '{re: 32'hFFFF_FF9C,  im: 32'd7,         div: 32'd101};
    vecs[6] = '{re: 32'h7FFF_FFFF,  im: 32'd0,         div: 32'h7FFF_FFFF};
    vecs[7] = '{re: 32'h4000_0000,  im: 32'h4000_0000, div: 32'h5800_0000};
    vecs[8] = '{re: 32'hFFFF_FFFF,  im: 32'hFFFF_FFFF, div: 32'd1};
    vecs[9] = '{re: 32'h6000_0000,  im: 32'hA000_0000, div: 32'h7FFF_FFFF};

    // Reset state
    repeat (2) @(posedge axis_aclk);
    #1;
    check("reset s_tready", s_axis.tready, 1);
    check("reset valids", {m00_axis.tvalid, m01_axis.tvalid}, 2'b00);
    check("reset m00 data", m00_axis.tdata, 64'd0);
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_vector(vecs[i], i);
    end

    // Random streaming: full rate, then skewed backpressure
    run_stream("stream", 4096, 100, 100, 100, 1'b1);
    run_stream("skew", 300, 80, 30, 70, 1'b0);

    // Split completion: m01 takes bin A at N, m00 held off until N+5
    @(posedge axis_aclk); #1;
    m00_axis.tready = 1'b0;
    m01_axis.tready = 1'b1;
    s_axis.tdata    = {32'd20, 32'd10};
    s_axis.tvalid   = 1'b1;
    @(posedge axis_aclk); #1;
    s_axis.tdata    = {32'hFFFF_FFE0, 32'd40};
    @(posedge axis_aclk); #1;
    s_axis.tvalid   = 1'b0;
    @(negedge axis_aclk);
    check("split N valids", {m00_axis.tvalid, m01_axis.tvalid}, 2'b11);
    check("split N m01 data", m01_axis.tdata, {32'd23, 32'd20});
    check("split N s_tready", s_axis.tready, 0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge axis_aclk); #1;
      if (i == 5) m00_axis.tready = 1'b1;
      @(negedge axis_aclk);
      check($sformatf("split N+%0d m01 valid", i), m01_axis.tvalid, 0);
      check($sformatf("split N+%0d m00 valid", i), m00_axis.tvalid, 1);
      check($sformatf("split N+%0d m00 data", i), m00_axis.tdata, {32'd23, 32'd10});
    end
    @(negedge axis_aclk);
    check("split N+6 valids", {m00_axis.tvalid, m01_axis.tvalid}, 2'b11);
    check("split N+6 m00 data", m00_axis.tdata, {32'd52, 32'd40});
    check("split N+6 m01 data", m01_axis.tdata, {32'd52, 32'hFFFF_FFE0});
    @(negedge axis_aclk);
    check("split N+7 valids", {m00_axis.tvalid, m01_axis.tvalid}, 2'b00);

    // Reset with both stages full
    @(posedge axis_aclk); #1;
    m00_axis.tready = 1'b0;
    m01_axis.tready = 1'b0;
    s_axis.tdata    = {32'd5, 32'd6};
    s_axis.tvalid   = 1'b1;
    repeat (4) @(posedge axis_aclk);
    @(negedge axis_aclk);
    check("prereset s_tready", s_axis.tready, 0);
    check("prereset valids", {m00_axis.tvalid, m01_axis.tvalid}, 2'b11);
    #2;
    axis_aresetn  = 1'b0;
    s_axis.tvalid = 1'b0;
    #1;
    check("reset async valids", {m00_axis.tvalid, m01_axis.tvalid}, 2'b00);
    check("reset async s_tready", s_axis.tready, 1);
    check("reset async m01 data", m01_axis.tdata, 64'd0);
    @(negedge axis_aclk);
    axis_aresetn    = 1'b1;
    m00_axis.tready = 1'b1;
    m01_axis.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_aclk);
      check($sformatf("post reset idle %0d", i), {m00_axis.tvalid, m01_axis.tvalid}, 2'b00);
    end
    run_vector(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
